// File: rtl/stepper_motion_ctrl.sv
// Stepper motor move sequencer: valid/ready move commands, full/half step, pause, abort, signed position.
// Define STEP_RAMP_EN to add a symmetric trapezoidal acceleration/deceleration ramp.
module stepper_motion_ctrl #(
    parameter int STEP_PERIOD = 100000,
    parameter int CNT_W       = 16,
    parameter int POS_W       = 24,
    parameter int RAMP_START  = 400000,
    parameter int RAMP_DEC    = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic             half_step,
    input  logic             enable,
    input  logic             stop,
    output logic [3:0]       coil,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_remaining,
    output logic [POS_W-1:0] position
);

    if (STEP_PERIOD < 2 || RAMP_START < STEP_PERIOD || RAMP_DEC < 0) begin : g_bad_cfg
        $error("stepper_motion_ctrl: invalid step timing parameters");
    end

    localparam logic [31:0]             SP_C    = 32'(STEP_PERIOD);
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                  state, state_next;
    logic [2:0]              phase;
    logic [31:0]             tick;
    logic [31:0]             period;
    logic [CNT_W-1:0]        remaining;
    logic signed [POS_W-1:0] pos;
    logic                    dir_lat, half_lat;
    logic                    busy_q, pend, done_q;
    logic                    accept, step, end_evt;

    function automatic logic [3:0] phase_pattern(input logic [2:0] p);
        case (p)
            3'd0:    return 4'b0001;
            3'd1:    return 4'b0011;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0100;
            3'd5:    return 4'b1100;
            3'd6:    return 4'b1000;
            default: return 4'b1001;
        endcase
    endfunction

    // Full-step mode lives on the odd (two-coil) indices; an even phase is first nudged by one.
    function automatic logic [2:0] next_phase(input logic [2:0] p, input logic half, input logic rev);
        logic [2:0] inc;
        inc = (half || !p[0]) ? 3'd1 : 3'd2;
        return rev ? p - inc : p + inc;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        end_evt    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept = 1'b1;
                    if (cmd_steps != '0) state_next = RUN;
                    else                 end_evt    = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                    end_evt    = 1'b1;
                end else if (enable && tick == period - 32'd1) begin
                    step = 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state_next = IDLE;
                        end_evt    = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The cycle after a move ends is still part of it: busy drops and done pulses one edge later.
    assign cmd_ready = (state == IDLE) && !stop && !pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= 3'd0;
            tick      <= 32'd0;
            remaining <= '0;
            pos       <= '0;
            dir_lat   <= 1'b0;
            half_lat  <= 1'b0;
            busy_q    <= 1'b0;
            pend      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pend   <= end_evt;
            done_q <= pend;
            if (pend) busy_q <= 1'b0;
            if (accept) begin
                remaining <= cmd_steps;
                dir_lat   <= cmd_dir;
                half_lat  <= half_step;
                tick      <= 32'd0;
                if (cmd_steps != '0) busy_q <= 1'b1;
            end
            if (state == RUN && !stop && enable) begin
                tick <= step ? 32'd0 : tick + 32'd1;
            end
            if (step) begin
                phase     <= next_phase(phase, half_lat, dir_lat);
                pos       <= dir_lat ? pos - POS_ONE : pos + POS_ONE;
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

`ifdef STEP_RAMP_EN
    localparam logic [31:0] START_C = 32'(RAMP_START);
    localparam logic [31:0] DEC_C   = 32'(RAMP_DEC);

    logic [31:0]      period_q;
    logic [CNT_W-1:0] accel;

    function automatic logic [31:0] ramp_up(input logic [31:0] p);
        logic [32:0] s;
        s = {1'b0, p} + {1'b0, DEC_C};
        return (s >= {1'b0, START_C}) ? START_C : s[31:0];
    endfunction

    function automatic logic [31:0] ramp_down(input logic [31:0] p);
        return (p >= SP_C + DEC_C) ? p - DEC_C : SP_C;
    endfunction

    // Deceleration mirrors acceleration: once the steps left fit in the accel count, slow back down.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= START_C;
            accel    <= '0;
        end else if (accept) begin
            period_q <= START_C;
            accel    <= '0;
        end else if (step) begin
            if ((remaining - CNT_W'(1)) <= accel) begin
                period_q <= ramp_up(period_q);
            end else if (period_q > SP_C) begin
                period_q <= ramp_down(period_q);
                accel    <= accel + CNT_W'(1);
            end
        end
    end

    assign period = period_q;
`else
    assign period = SP_C;
`endif

    assign coil            = enable ? phase_pattern(phase) : 4'b0000;
    assign busy            = busy_q;
    assign done            = done_q;
    assign steps_remaining = remaining;
    assign position        = pos;

endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// Directed bench for stepper_motion_ctrl with STEP_PERIOD=4; the ramp case runs when STEP_RAMP_EN is defined.
module tb_stepper_motion_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic        half_step;
    logic        enable;
    logic        stop;
    logic [3:0]  coil;
    logic        busy;
    logic        done;
    logic [15:0] steps_remaining;
    logic [23:0] position;

    int nchk = 0;
    int nbad = 0;
    int ndone;
    int dcyc;

    always #5 clk = ~clk;

    stepper_motion_ctrl #(
        .STEP_PERIOD(4),
        .CNT_W(16),
        .POS_W(24),
        .RAMP_START(12),
        .RAMP_DEC(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps),
        .cmd_dir(cmd_dir),
        .half_step(half_step),
        .enable(enable),
        .stop(stop),
        .coil(coil),
        .busy(busy),
        .done(done),
        .steps_remaining(steps_remaining),
        .position(position)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic send(input logic [15:0] n, input logic d, input logic hs);
        cmd_steps = n;
        cmd_dir   = d;
        half_step = hs;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
    endtask

`ifdef STEP_RAMP_EN
    int step_at [6];
    int exp_at  [6] = '{12, 20, 24, 28, 36, 48};
    int nstep;
    logic [23:0] last_pos;
`endif

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_steps = 16'd0;
        cmd_dir   = 1'b0;
        half_step = 1'b0;
        enable    = 1'b0;
        stop      = 1'b0;

        // reset and idle
        #2;
        chk("rst_coil", coil, 4'b0000);
        chk("rst_pos", position, 24'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rem", steps_remaining, 16'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();
        chk("idle_ready", cmd_ready, 1'b1);
        chk("idle_done", done, 1'b0);
        chk("idle_coil_dis", coil, 4'b0000);
        enable = 1'b1;
        #1;
        chk("idle_coil_en", coil, 4'b0001);

        // forward half-step, 3 steps
        ndone = 0; dcyc = -1;
        send(16'd3, 1'b0, 1'b1);
        chk("fwd_busy_c0", busy, 1'b1);
        chk("fwd_rem_c0", steps_remaining, 16'd3);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (done) begin ndone++; dcyc = k; end
            if (k == 3)  chk("fwd_coil_c3", coil, 4'b0001);
            if (k == 4)  chk("fwd_coil_c4", coil, 4'b0011);
            if (k == 8)  chk("fwd_coil_c8", coil, 4'b0010);
            if (k == 12) begin
                chk("fwd_coil_c12", coil, 4'b0110);
                chk("fwd_busy_c12", busy, 1'b1);
            end
            if (k == 13) begin
                chk("fwd_busy_c13", busy, 1'b0);
                chk("fwd_pos", position, 24'd3);
            end
        end
        chk("fwd_done_cnt", ndone, 1);
        chk("fwd_done_cyc", dcyc, 13);

        // reverse full-step from phase 0; mid-move mode/dir changes ignored
        do_reset();
        ndone = 0; dcyc = -1;
        send(16'd2, 1'b1, 1'b0);
        half_step = 1'b1;
        cmd_dir   = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            cyc();
            if (done) begin ndone++; dcyc = k; end
            if (k == 4) chk("rev_coil_c4", coil, 4'b1001);
            if (k == 8) chk("rev_coil_c8", coil, 4'b1100);
        end
        chk("rev_pos", position, 24'hFF_FFFE);
        chk("rev_rem", steps_remaining, 16'd0);
        chk("rev_done_cyc", dcyc, 9);

        // abort coinciding with the 4th step tick
        do_reset();
        ndone = 0; dcyc = -1;
        half_step = 1'b0;
        send(16'd10, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (done) begin ndone++; dcyc = k; end
            if (k == 4)  chk("abt_coil_c4", coil, 4'b0011);
            if (k == 12) chk("abt_coil_c12", coil, 4'b1100);
            if (k == 15) stop = 1'b1;
            if (k == 16) begin
                chk("abt_coil_c16", coil, 4'b1100);
                chk("abt_pos", position, 24'd3);
                chk("abt_rem", steps_remaining, 16'd7);
                stop = 1'b0;
            end
            if (k == 17) chk("abt_busy_c17", busy, 1'b0);
        end
        chk("abt_done_cnt", ndone, 1);
        chk("abt_done_cyc", dcyc, 17);

        // stop in idle blocks acceptance
        stop = 1'b1;
        #1;
        chk("idle_stop_ready", cmd_ready, 1'b0);
        cmd_steps = 16'd5;
        cmd_valid = 1'b1;
        cyc();
        cyc();
        cmd_valid = 1'b0;
        chk("idle_stop_busy", busy, 1'b0);
        chk("idle_stop_rem", steps_remaining, 16'd7);
        stop = 1'b0;
        cyc();

        // pause: half-step forward 5 from phase 5, enable low for 20 cycles
        ndone = 0; dcyc = -1;
        send(16'd5, 1'b0, 1'b1);
        for (int k = 1; k <= 44; k++) begin
            cyc();
            if (done) begin ndone++; dcyc = k; end
            if (k == 4)  chk("pse_coil_c4", coil, 4'b1000);
            if (k == 8)  chk("pse_pos_c8", position, 24'd5);
            if (k == 10) enable = 1'b0;
            if (k == 20) begin
                chk("pse_coil_off", coil, 4'b0000);
                chk("pse_pos_c20", position, 24'd5);
            end
            if (k == 29) chk("pse_pos_c29", position, 24'd5);
            if (k == 30) enable = 1'b1;
            if (k == 31) begin
                chk("pse_coil_c31", coil, 4'b1001);
                chk("pse_pos_c31", position, 24'd5);
            end
            if (k == 32) chk("pse_pos_c32", position, 24'd6);
        end
        chk("pse_done_cyc", dcyc, 41);
        chk("pse_done_cnt", ndone, 1);
        chk("pse_pos_end", position, 24'd8);
        chk("pse_coil_end", coil, 4'b0010);

        // zero-length move
        send(16'd0, 1'b0, 1'b0);
        chk("zero_done_c0", done, 1'b0);
        cyc();
        chk("zero_done_c1", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        chk("zero_coil", coil, 4'b0010);
        chk("zero_pos", position, 24'd8);
        cyc();
        chk("zero_done_c2", done, 1'b0);
        chk("zero_ready", cmd_ready, 1'b1);

`ifdef STEP_RAMP_EN
        // ramp 12 -> 4 -> 12 with DEC=4, 6 steps
        do_reset();
        nstep = 0; dcyc = -1;
        last_pos = position;
        send(16'd6, 1'b0, 1'b1);
        for (int k = 1; k <= 55; k++) begin
            cyc();
            if (done) dcyc = k;
            if (position != last_pos) begin
                if (nstep < 6) step_at[nstep] = k;
                nstep++;
                last_pos = position;
            end
        end
        chk("ramp_nstep", nstep, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < nstep) chk($sformatf("ramp_step%0d", i), step_at[i], exp_at[i]);
        end
        chk("ramp_done_cyc", dcyc, 49);
`endif

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
